// File: rtl/jtag_tap_scan.sv
// IEEE 1149.1-style test access block with a BIST/MISR mode on the boundary register.
// Everything runs on ck. Capture, shift and update are enables decoded from the TAP
// state, so there are no derived clocks.
// Ports:
//   ck, reset_n    : system clock, synchronous active-low reset
//   TMS, TDI       : test mode select, serial data in
//   TDO, TDO_en    : serial data out (combinational), high only in Shift-DR/Shift-IR
//   sys_in/sys_out : pin/core data through the boundary cells
//   inst           : current (updated) instruction
//   tap_state      : current TAP controller state encoding
module jtag_tap_scan #(
  parameter int unsigned          IR_W      = 2,
  parameter int unsigned          BSR_LEN   = 8,
  parameter logic [BSR_LEN-1:0]   LFSR_TAPS = 8'hB8,
  parameter int unsigned          OP_SAMPLE = 0,
  parameter int unsigned          OP_EXTEST = 1,
  parameter int unsigned          OP_BIST   = 2
) (
  input  logic               ck,
  input  logic               reset_n,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_en,
  input  logic [BSR_LEN-1:0] sys_in,
  output logic [BSR_LEN-1:0] sys_out,
  output logic [IR_W-1:0]    inst,
  output logic [3:0]         tap_state
);

  typedef enum logic [3:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDDR   = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPDIR   = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] INST_SAMPLE = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] INST_EXTEST = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] INST_BIST   = IR_W'(OP_BIST);
  localparam logic [IR_W-1:0] INST_BYPASS = '1;

  tap_state_e         state_q, state_d;
  logic [IR_W-1:0]    inst_q, inst_d;
  logic [IR_W-1:0]    ir_sh_q, ir_sh_d;
  logic [BSR_LEN-1:0] bsr_q, bsr_d;
  logic [BSR_LEN-1:0] upd_q, upd_d;
  logic               byp_q, byp_d;

  logic bsr_sel;
  logic bist_sel;
  logic extest_sel;
  logic misr_fb;

  // Instruction decode: all-ones always wins as BYPASS, anything undefined is BYPASS too.
  always_comb begin
    bist_sel   = (inst_q == INST_BIST)   && (inst_q != INST_BYPASS);
    extest_sel = (inst_q == INST_EXTEST) && (inst_q != INST_BYPASS);
    bsr_sel    = ((inst_q == INST_SAMPLE) || extest_sel || bist_sel) &&
                 (inst_q != INST_BYPASS);
    misr_fb    = ^(bsr_q & LFSR_TAPS);
  end

  // TAP controller next state on TMS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:     state_d = TMS ? ST_TLR     : ST_RTI;
      ST_RTI:     state_d = TMS ? ST_SELDR   : ST_RTI;
      ST_SELDR:   state_d = TMS ? ST_SELIR   : ST_CAPDR;
      ST_CAPDR:   state_d = TMS ? ST_EX1DR   : ST_SHDR;
      ST_SHDR:    state_d = TMS ? ST_EX1DR   : ST_SHDR;
      ST_EX1DR:   state_d = TMS ? ST_UPDDR   : ST_PAUSEDR;
      ST_PAUSEDR: state_d = TMS ? ST_EX2DR   : ST_PAUSEDR;
      ST_EX2DR:   state_d = TMS ? ST_UPDDR   : ST_SHDR;
      ST_UPDDR:   state_d = TMS ? ST_SELDR   : ST_RTI;
      ST_SELIR:   state_d = TMS ? ST_TLR     : ST_CAPIR;
      ST_CAPIR:   state_d = TMS ? ST_EX1IR   : ST_SHIR;
      ST_SHIR:    state_d = TMS ? ST_EX1IR   : ST_SHIR;
      ST_EX1IR:   state_d = TMS ? ST_UPDIR   : ST_PAUSEIR;
      ST_PAUSEIR: state_d = TMS ? ST_EX2IR   : ST_PAUSEIR;
      ST_EX2IR:   state_d = TMS ? ST_UPDIR   : ST_SHIR;
      ST_UPDIR:   state_d = TMS ? ST_SELDR   : ST_RTI;
      default:    state_d = ST_TLR;
    endcase
  end

  // Register actions keyed on the state present at the edge; pause/exit states hold.
  always_comb begin
    inst_d  = inst_q;
    ir_sh_d = ir_sh_q;
    bsr_d   = bsr_q;
    upd_d   = upd_q;
    byp_d   = byp_q;
    case (state_q)
      ST_TLR:   inst_d  = INST_BYPASS;
      ST_CAPIR: ir_sh_d = IR_W'(1);
      ST_SHIR:  ir_sh_d = {TDI, ir_sh_q[IR_W-1:1]};
      ST_UPDIR: inst_d  = ir_sh_q;
      ST_CAPDR: begin
        // BIST keeps its signature in the BSR instead of sampling the pins.
        if (bsr_sel) begin
          if (!bist_sel) bsr_d = sys_in;
        end else begin
          byp_d = 1'b0;
        end
      end
      ST_SHDR: begin
        if (bsr_sel) bsr_d = {TDI, bsr_q[BSR_LEN-1:1]};
        else         byp_d = TDI;
      end
      ST_UPDDR: begin
        if (bsr_sel) upd_d = bsr_q;
      end
      ST_RTI: begin
        // MISR compaction of sys_in while idling under BIST.
        if (bist_sel) bsr_d = {misr_fb, bsr_q[BSR_LEN-1:1]} ^ sys_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!reset_n) begin
      state_q <= ST_TLR;
      inst_q  <= INST_BYPASS;
      ir_sh_q <= '0;
      bsr_q   <= '0;
      upd_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ir_sh_q <= ir_sh_d;
      bsr_q   <= bsr_d;
      upd_q   <= upd_d;
      byp_q   <= byp_d;
    end
  end

  // Serial output and pin mux.
  always_comb begin
    TDO    = 1'b0;
    TDO_en = 1'b0;
    if (state_q == ST_SHIR) begin
      TDO    = ir_sh_q[0];
      TDO_en = 1'b1;
    end else if (state_q == ST_SHDR) begin
      TDO    = bsr_sel ? bsr_q[0] : byp_q;
      TDO_en = 1'b1;
    end
    sys_out = extest_sel ? upd_q : sys_in;
  end

  assign inst      = inst_q;
  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_scan.sv
// Bench for jtag_tap_scan: directed vector table with hand-derived expectations,
// then random TMS/TDI/sys_in/reset compared against a table-driven reference model.
// A second instance with OP_BIST=3 shows opcode 2'b10 falling back to BYPASS.
module tb_jtag_tap_scan;

  localparam int unsigned IR_W    = 2;
  localparam int unsigned BSR_LEN = 8;
  localparam logic [7:0]  TAPS    = 8'hB8;
  localparam logic [1:0]  OP_S    = 2'd0;
  localparam logic [1:0]  OP_E    = 2'd1;
  localparam logic [1:0]  OP_B    = 2'd2;

  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2, S_PDR = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR = 4'hA, S_PIR = 4'hB;
  localparam logic [3:0] S_RTI = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR = 4'hF;

  logic ck = 1'b0;
  logic reset_n, TMS, TDI;
  logic [7:0] sys_in;
  logic tdo, tdo_en, tdo3, tdo_en3;
  logic [7:0] sys_out, sys_out3;
  logic [1:0] inst, inst3;
  logic [3:0] tap_state, tap_state3;

  always #5 ck = ~ck;

  jtag_tap_scan #(.IR_W(IR_W), .BSR_LEN(BSR_LEN)) u_dut (
    .ck(ck), .reset_n(reset_n), .TMS(TMS), .TDI(TDI), .TDO(tdo), .TDO_en(tdo_en),
    .sys_in(sys_in), .sys_out(sys_out), .inst(inst), .tap_state(tap_state)
  );

  jtag_tap_scan #(.IR_W(IR_W), .BSR_LEN(BSR_LEN), .OP_BIST(3)) u_dut3 (
    .ck(ck), .reset_n(reset_n), .TMS(TMS), .TDI(TDI), .TDO(tdo3), .TDO_en(tdo_en3),
    .sys_in(sys_in), .sys_out(sys_out3), .inst(inst3), .tap_state(tap_state3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] nxt [16][2];
  logic [3:0] m_st;
  logic [1:0] m_inst, m_ir;
  logic [7:0] m_bsr, m_upd;
  logic       m_byp;

  task automatic set_arc(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nxt[s][0] = on0;
    nxt[s][1] = on1;
  endtask

  task automatic init_model();
    set_arc(S_TLR,   S_RTI,   S_TLR);
    set_arc(S_RTI,   S_RTI,   S_SELDR);
    set_arc(S_SELDR, S_CAPDR, S_SELIR);
    set_arc(S_CAPDR, S_SHDR,  S_EX1DR);
    set_arc(S_SHDR,  S_SHDR,  S_EX1DR);
    set_arc(S_EX1DR, S_PDR,   S_UPDDR);
    set_arc(S_PDR,   S_PDR,   S_EX2DR);
    set_arc(S_EX2DR, S_SHDR,  S_UPDDR);
    set_arc(S_UPDDR, S_RTI,   S_SELDR);
    set_arc(S_SELIR, S_CAPIR, S_TLR);
    set_arc(S_CAPIR, S_SHIR,  S_EX1IR);
    set_arc(S_SHIR,  S_SHIR,  S_EX1IR);
    set_arc(S_EX1IR, S_PIR,   S_UPDIR);
    set_arc(S_PIR,   S_PIR,   S_EX2IR);
    set_arc(S_EX2IR, S_SHIR,  S_UPDIR);
    set_arc(S_UPDIR, S_RTI,   S_SELDR);
  endtask

  function automatic logic uses_bsr(input logic [1:0] i);
    return (i != 2'b11) && (i == OP_S || i == OP_E || i == OP_B);
  endfunction

  // One rising edge of the model with the inputs held across it.
  task automatic model_clk(input logic r, input logic t, input logic d, input logic [7:0] s);
    logic sel, fb;
    logic [7:0] shifted;
    if (!r) begin
      m_st = S_TLR; m_inst = 2'b11; m_ir = 2'b00;
      m_bsr = 8'h00; m_upd = 8'h00; m_byp = 1'b0;
      return;
    end
    sel = uses_bsr(m_inst);
    if (m_st == S_TLR)   m_inst = 2'b11;
    if (m_st == S_UPDIR) m_inst = m_ir;
    if (m_st == S_CAPIR) m_ir   = 2'b01;
    if (m_st == S_SHIR)  m_ir   = {d, m_ir[1]};
    if (sel && m_st == S_CAPDR && m_inst != OP_B) m_bsr = s;
    if (sel && m_st == S_UPDDR) m_upd = m_bsr;
    if (sel && m_st == S_SHDR) m_bsr = (m_bsr >> 1) | {d, 7'b0};
    if (!sel && m_st == S_CAPDR) m_byp = 1'b0;
    if (!sel && m_st == S_SHDR)  m_byp = d;
    if (m_st == S_RTI && m_inst == OP_B) begin
      fb = 1'b0;
      for (int k = 0; k < 8; k++) if (TAPS[k]) fb = fb ^ m_bsr[k];
      shifted = (m_bsr >> 1) | {fb, 7'b0};
      m_bsr   = shifted ^ s;
    end
    m_st = nxt[m_st][t];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic r, input logic t, input logic d, input logic [7:0] s);
    @(negedge ck);
    reset_n = r; TMS = t; TDI = d; sys_in = s;
    #1;
  endtask

  task automatic advance();
    @(posedge ck);
    model_clk(reset_n, TMS, TDI, sys_in);
  endtask

  typedef struct {
    logic       r, t, d;
    logic [7:0] s;
    logic [3:0] st;
    logic [1:0] ins;
    logic [1:0] m;      // bit0: check TDO, bit1: check TDO of OP_BIST=3 instance
    logic       tdo, tdo3;
    logic [7:0] so;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic t, input logic d, input logic [7:0] s,
                     input logic [3:0] st, input logic [1:0] ins, input logic [1:0] m,
                     input logic tdo_e, input logic tdo3_e, input logic [7:0] so);
    vec_t v;
    v.r = r; v.t = t; v.d = d; v.s = s; v.st = st; v.ins = ins;
    v.m = m; v.tdo = tdo_e; v.tdo3 = tdo3_e; v.so = so;
    vt.push_back(v);
  endtask

  task automatic addn(input logic t, input logic d, input logic [7:0] s,
                      input logic [3:0] st, input logic [1:0] ins, input logic [7:0] so);
    add(1'b1, t, d, s, st, ins, 2'b00, 1'b0, 1'b0, so);
  endtask

  task automatic build_table();
    logic [7:0] pat, cap, seed, sig;
    pat = 8'hA5; cap = 8'h3C; seed = 8'h80; sig = 8'h70;
    // reset state, walk into Shift-DR, reset there
    addn(0, 0, 8'h5A, 4'hF, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h6, 2'd3, 8'h5A);
    add(1'b0, 0, 0, 8'h5A, 4'h2, 2'd3, 2'b11, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'hF, 2'd3, 8'h5A);
    // five TMS=1 from Shift-DR
    addn(0, 0, 8'h5A, 4'hF, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h6, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h2, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h1, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h5, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h4, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'hF, 2'd3, 8'h5A);
    // Pause-IR exit with TMS=1: B->8->D->7->4->F (UpdIR loads captured 01)
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h4, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hE, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h9, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hB, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h8, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hD, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h7, 2'd1, 8'h00);
    addn(1, 0, 8'h5A, 4'h4, 2'd1, 8'h00);
    addn(0, 0, 8'h5A, 4'hF, 2'd1, 8'h00);
    // IR load of EXTEST by shifting 1 then 0
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h4, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'hE, 2'd3, 8'h5A);
    add(1'b1, 0, 1, 8'h5A, 4'hA, 2'd3, 2'b01, 1'b1, 1'b0, 8'h5A);
    add(1'b1, 1, 0, 8'h5A, 4'hA, 2'd3, 2'b01, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'h9, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'hD, 2'd3, 8'h5A);
    // EXTEST: capture 3C, shift in A5, update drives pins
    addn(1, 0, 8'h3C, 4'hC, 2'd1, 8'h00);
    addn(0, 0, 8'h3C, 4'h7, 2'd1, 8'h00);
    addn(0, 0, 8'h3C, 4'h6, 2'd1, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1'b1, (i == 7), pat[i], 8'h3C, 4'h2, 2'd1, 2'b01, cap[i], 1'b0, 8'h00);
    addn(1, 0, 8'h3C, 4'h1, 2'd1, 8'h00);
    addn(0, 0, 8'h3C, 4'h5, 2'd1, 8'h00);
    addn(0, 0, 8'h00, 4'hC, 2'd1, 8'hA5);
    addn(0, 0, 8'hFF, 4'hC, 2'd1, 8'hA5);
    // IR load of BYPASS (11), then 3-bit bypass scan
    addn(1, 0, 8'hFF, 4'hC, 2'd1, 8'hA5);
    addn(1, 0, 8'hFF, 4'h7, 2'd1, 8'hA5);
    addn(0, 0, 8'hFF, 4'h4, 2'd1, 8'hA5);
    addn(0, 0, 8'hFF, 4'hE, 2'd1, 8'hA5);
    add(1'b1, 0, 1, 8'hFF, 4'hA, 2'd1, 2'b01, 1'b1, 1'b0, 8'hA5);
    add(1'b1, 1, 1, 8'hFF, 4'hA, 2'd1, 2'b01, 1'b0, 1'b0, 8'hA5);
    addn(1, 0, 8'hFF, 4'h9, 2'd1, 8'hA5);
    addn(0, 0, 8'hFF, 4'hD, 2'd1, 8'hA5);
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h6, 2'd3, 8'h5A);
    add(1'b1, 0, 1, 8'h5A, 4'h2, 2'd3, 2'b11, 1'b0, 1'b0, 8'h5A);
    add(1'b1, 0, 0, 8'h5A, 4'h2, 2'd3, 2'b11, 1'b1, 1'b1, 8'h5A);
    add(1'b1, 1, 1, 8'h5A, 4'h2, 2'd3, 2'b11, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'h1, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h5, 2'd3, 8'h5A);
    // IR load of 10: BIST here, undefined (bypass) in the OP_BIST=3 instance
    addn(1, 0, 8'h5A, 4'hC, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'h7, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'h4, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'hE, 2'd3, 8'h5A);
    add(1'b1, 0, 0, 8'h5A, 4'hA, 2'd3, 2'b01, 1'b1, 1'b0, 8'h5A);
    add(1'b1, 1, 1, 8'h5A, 4'hA, 2'd3, 2'b01, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'h9, 2'd3, 8'h5A);
    addn(0, 0, 8'h5A, 4'hD, 2'd3, 8'h5A);
    addn(1, 0, 8'h5A, 4'hC, 2'd2, 8'h5A);
    addn(0, 0, 8'h5A, 4'h7, 2'd2, 8'h5A);
    addn(0, 0, 8'h5A, 4'h6, 2'd2, 8'h5A);
    add(1'b1, 0, 1, 8'h5A, 4'h2, 2'd2, 2'b10, 1'b0, 1'b0, 8'h5A);
    add(1'b1, 0, 0, 8'h5A, 4'h2, 2'd2, 2'b10, 1'b0, 1'b1, 8'h5A);
    add(1'b1, 1, 1, 8'h5A, 4'h2, 2'd2, 2'b10, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'h1, 2'd2, 8'h5A);
    addn(1, 0, 8'h5A, 4'h5, 2'd2, 8'h5A);
    // seed 80, three MISR edges in RTI with sys_in=0 -> 70, capture holds, shift out
    addn(0, 0, 8'h5A, 4'h7, 2'd2, 8'h5A);
    addn(0, 0, 8'h5A, 4'h6, 2'd2, 8'h5A);
    for (int i = 0; i < 8; i++)
      add(1'b1, (i == 7), seed[i], 8'h5A, 4'h2, 2'd2, 2'b00, 1'b0, 1'b0, 8'h5A);
    addn(1, 0, 8'h5A, 4'h1, 2'd2, 8'h5A);
    addn(0, 0, 8'h00, 4'h5, 2'd2, 8'h00);
    addn(0, 0, 8'h00, 4'hC, 2'd2, 8'h00);
    addn(0, 0, 8'h00, 4'hC, 2'd2, 8'h00);
    addn(1, 0, 8'h00, 4'hC, 2'd2, 8'h00);
    addn(0, 0, 8'h00, 4'h7, 2'd2, 8'h00);
    addn(0, 0, 8'h00, 4'h6, 2'd2, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1'b1, (i == 7), 1'b0, 8'h00, 4'h2, 2'd2, 2'b01, sig[i], 1'b0, 8'h00);
    addn(1, 0, 8'h00, 4'h1, 2'd2, 8'h00);
    addn(1, 0, 8'h00, 4'h5, 2'd2, 8'h00);
    addn(1, 0, 8'h00, 4'h7, 2'd2, 8'h00);
    addn(1, 0, 8'h00, 4'h4, 2'd2, 8'h00);
    addn(1, 0, 8'h00, 4'hF, 2'd2, 8'h00);
  endtask

  initial begin
    logic r, t, d;
    logic [7:0] s;
    reset_n = 1'b0; TMS = 1'b1; TDI = 1'b0; sys_in = 8'h00;
    init_model();
    build_table();

    apply(1'b0, 1'b1, 1'b0, 8'h5A); advance();
    apply(1'b0, 1'b1, 1'b0, 8'h5A); advance();

    foreach (vt[i]) begin
      apply(vt[i].r, vt[i].t, vt[i].d, vt[i].s);
      chk($sformatf("row%0d tap_state", i), 32'(tap_state), 32'(vt[i].st));
      chk($sformatf("row%0d inst", i), 32'(inst), 32'(vt[i].ins));
      chk($sformatf("row%0d sys_out", i), 32'(sys_out), 32'(vt[i].so));
      if (vt[i].m[0]) chk($sformatf("row%0d TDO", i), 32'(tdo), 32'(vt[i].tdo));
      if (vt[i].m[1]) chk($sformatf("row%0d TDO(opbist3)", i), 32'(tdo3), 32'(vt[i].tdo3));
      advance();
    end

    // random phase against the model
    apply(1'b0, 1'b1, 1'b0, 8'h00); advance();
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) != 0);
      t = ($urandom_range(0, 9) < 4);
      d = 1'($urandom);
      s = 8'($urandom);
      apply(r, t, d, s);
      chk($sformatf("rnd%0d tap_state", n), 32'(tap_state), 32'(m_st));
      chk($sformatf("rnd%0d inst", n), 32'(inst), 32'(m_inst));
      chk($sformatf("rnd%0d TDO", n),
          32'(tdo),
          32'((m_st == S_SHIR) ? m_ir[0] :
              (m_st == S_SHDR) ? (uses_bsr(m_inst) ? m_bsr[0] : m_byp) : 1'b0));
      chk($sformatf("rnd%0d TDO_en", n), 32'(tdo_en), 32'(m_st == S_SHIR || m_st == S_SHDR));
      chk($sformatf("rnd%0d sys_out", n), 32'(sys_out), 32'((m_inst == OP_E) ? m_upd : s));
      chk($sformatf("rnd%0d tap_state(opbist3)", n), 32'(tap_state3), 32'(m_st));
      chk($sformatf("rnd%0d inst(opbist3)", n), 32'(inst3), 32'(m_inst));
      chk($sformatf("rnd%0d TDO_en(opbist3)", n), 32'(tdo_en3), 32'(m_st == S_SHIR || m_st == S_SHDR));
      chk($sformatf("rnd%0d sys_out(opbist3)", n), 32'(sys_out3), 32'((m_inst == OP_E) ? m_upd : s));
      if (m_inst != OP_B)
        chk($sformatf("rnd%0d TDO(opbist3)", n), 32'(tdo3), 32'(tdo === 1'bx ? 1'b0 :
            ((m_st == S_SHIR) ? m_ir[0] :
             (m_st == S_SHDR) ? (uses_bsr(m_inst) ? m_bsr[0] : m_byp) : 1'b0)));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_scan.md
Name: jtag_tap_scan

Overview:
- Parametrised IEEE 1149.1-style test access block: full 16-state TAP controller, IR_W-bit instruction register, BSR_LEN-bit boundary scan register and 1-bit bypass register.
- Adds a BIST/MISR mode to the BSR.
- The whole block runs on the single system clock: capture, shift and update are clock enables decoded from TAP state, not separate clocks.
- Sits between chip I/O and core logic. It replaces the hand-built scan-cell chain and fixed 2-bit instruction register.

Parameters:
- IR_W, 2, instruction register width (>=2).
- BSR_LEN, 8, boundary scan register length (>=2).
- LFSR_TAPS, 8'hB8, BSR_LEN-bit feedback tap mask for BIST mode.
- OP_SAMPLE, 0, SAMPLE opcode.
- OP_EXTEST, 1, EXTEST opcode.
- OP_BIST, 2, BIST opcode.
- Opcode all-ones is always BYPASS. Any undefined opcode decodes as BYPASS.

Ports:
- ck  in  1  system/test clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- TMS  in  1  test mode select.
- TDI  in  1  serial test data in.
- TDO  out  1  serial test data out.
- TDO_en  out  1  high in Shift-DR/Shift-IR only.
- sys_in  in  BSR_LEN  core/pin data into the boundary cells.
- sys_out  out  BSR_LEN  data driven out of the boundary cells.
- inst  out  IR_W  current (updated) instruction.
- tap_state  out  4  current TAP state encoding.

Behaviour:
- TAP state encoding:
  - TLR=F, RTI=C.
  - DR path: SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
  - IR path: SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Transitions are standard 1149.1 on TMS at each rising edge, e.g. TLR -TMS0-> RTI, RTI -1-> SelDR, SelDR -1-> SelIR, SelIR -1-> TLR, UpdDR/UpdIR -0-> RTI, -1-> SelDR.
- Five consecutive TMS=1 cycles reach TLR from any state.
- Reset: reset_n=0 at an edge forces tap_state=TLR, inst=all-ones (BYPASS), ir_sh=0, bsr=0, upd=0, byp=0. Reset mid-shift aborts the shift with no update.
- In TLR, inst is forced to all-ones every cycle.
- Action rule: each register action happens on the edge where tap_state equals the named state.
- IR:
  - CapIR: ir_sh <= {0..0,2'b01}.
  - ShIR: ir_sh <= {TDI, ir_sh[IR_W-1:1]}.
  - UpdIR: inst <= ir_sh.
  - inst is stable otherwise.
- BSR (selected when inst is SAMPLE, EXTEST or BIST):
  - CapDR: bsr <= sys_in, except when inst=BIST (bsr holds).
  - ShDR: bsr <= {TDI, bsr[BSR_LEN-1:1]}.
  - UpdDR: upd <= bsr.
- BYPASS:
  - CapDR: byp <= 0.
  - ShDR: byp <= TDI.
- BIST:
  - While tap_state=RTI and inst=BIST, each edge: fb = ^(bsr & LFSR_TAPS); bsr <= {fb, bsr[BSR_LEN-1:1]} ^ sys_in (MISR).
  - Seed is loaded via ShDR beforehand.
- TDO (combinational):
  - ShIR: ir_sh[0].
  - ShDR: bsr[0] if BSR selected, byp if bypass selected.
  - Otherwise: 0.
- sys_out = upd when inst=EXTEST, else sys_in (transparent). The switch takes effect the cycle after UpdIR.
- Pause states hold all shift registers unchanged.

Test Plan:
- Reset: reset_n=0 one edge from ShDR -> tap_state=F, inst=2'b11, sys_out==sys_in (drive sys_in=8'h5A, see 8'h5A).
- TMS=1 for 5 edges from ShDR (state 2) -> tap_state=F. From PauseIR with 4 edges -> tap_state=F after the 4th? No: 4 edges give SelIR->TLR path. Check the exact sequence B->8->D->7->4, then 5th edge -> F.
- IR load: RTI, TMS 1,1,0,0 -> ShIR. Shift TDI 1 then 0 (TMS=1 on 2nd) -> TDO 1,0. TMS 1,0 -> UpdIR, then RTI: inst=2'b01.
- EXTEST: sys_in=8'h3C, CapDR then 8 ShDR cycles with TDI = 8'hA5 LSB-first -> TDO sequence 0,0,1,1,1,1,0,0. After UpdDR, sys_out=8'hA5 and holds while sys_in toggles.
- BYPASS: inst=11, ShDR with TDI 1,0,1 -> TDO 0,1,0. Undefined opcode 2'b10 with OP_BIST changed to 3 -> same bypass behaviour.
- BIST: inst=2'b10, seed bsr=8'h80 via ShDR, sys_in=0, 3 edges in RTI -> bsr=8'h70. Then CapDR (holds) and shift out -> TDO 0,0,0,0,1,1,1,0.
